// File: rtl/select_logic.sv
// Issue-select stage: round-robin pick of one ready RS entry per cycle, gated by
// per-FU occupancy, with grant/clear strobes to wakeup and a valid/ready issue register.
module select_logic #(
    parameter int NUM_ENTRIES = 16,
    parameter int NUM_FUS     = 4,
    parameter int IDX_W       = $clog2(NUM_ENTRIES),
    parameter int FU_W        = $clog2(NUM_FUS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_ENTRIES-1:0]         request_vector,
    input  logic [NUM_ENTRIES*FU_W-1:0]    entry_fu,
    input  logic [NUM_FUS*4-1:0]           fu_occupancy,
    input  logic                           flush,
    output logic                           grant_en,
    output logic [IDX_W-1:0]               grant_index,
    output logic                           clear_en,
    output logic [NUM_ENTRIES*NUM_FUS-1:0] clear_lines,
    output logic                           issue_valid,
    output logic [IDX_W-1:0]               issue_index,
    output logic [FU_W-1:0]                issue_fu,
    input  logic                           issue_ready
);

    logic [IDX_W-1:0]               rr_ptr;
    logic [NUM_ENTRIES-1:0]         pending;
    logic [3:0]                     busy_cnt [NUM_FUS];

    logic [NUM_FUS-1:0]             fu_free_p0;
    logic [NUM_ENTRIES-1:0]         eligible_p0;
    logic [IDX_W-1:0]               scan_idx_p0;
    logic                           pick_found_p0;
    logic [IDX_W-1:0]               pick_idx_p0;
    logic [FU_W-1:0]                pick_fu_p0;
    logic                           can_grant_p0;
    logic [NUM_ENTRIES*NUM_FUS-1:0] clear_next_p0;
    logic [NUM_ENTRIES-1:0]         pending_next_p0;

    // Occupancy 0 and 1 both mean fully pipelined: no blocking cycles.
    function automatic logic [3:0] occ_load(input logic [3:0] occ);
        return (occ == 4'd0) ? 4'd0 : occ - 4'd1;
    endfunction

    function automatic logic [3:0] dec_sat(input logic [3:0] cnt);
        return (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    endfunction

    always_comb begin
        fu_free_p0 = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            fu_free_p0[f] = (busy_cnt[f] == 4'd0);
        end
    end

    always_comb begin
        eligible_p0 = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            eligible_p0[e] = request_vector[e] & ~pending[e] &
                             fu_free_p0[entry_fu[e*FU_W +: FU_W]];
        end
    end

    // Round-robin scan starting at rr_ptr; index arithmetic wraps naturally.
    always_comb begin
        pick_found_p0 = 1'b0;
        pick_idx_p0   = rr_ptr;
        scan_idx_p0   = rr_ptr;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            scan_idx_p0 = rr_ptr + IDX_W'(i);
            if (!pick_found_p0 && eligible_p0[scan_idx_p0]) begin
                pick_found_p0 = 1'b1;
                pick_idx_p0   = scan_idx_p0;
            end
        end
    end

    always_comb begin
        pick_fu_p0      = entry_fu[int'(pick_idx_p0)*FU_W +: FU_W];
        can_grant_p0    = pick_found_p0 & (~issue_valid | issue_ready) & ~flush;
        clear_next_p0   = '0;
        clear_next_p0[int'(pick_fu_p0)*NUM_ENTRIES + int'(pick_idx_p0)] = 1'b1;
        pending_next_p0 = '0;
        pending_next_p0[pick_idx_p0] = 1'b1;
    end

    // ---- p0 -> p1: grant strobes, issue register, scheduler state ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_en    <= 1'b0;
            grant_index <= '0;
            clear_en    <= 1'b0;
            clear_lines <= '0;
            issue_valid <= 1'b0;
            issue_index <= '0;
            issue_fu    <= '0;
            rr_ptr      <= '0;
            pending     <= '0;
            for (int f = 0; f < NUM_FUS; f++) begin
                busy_cnt[f] <= 4'd0;
            end
        end else if (flush) begin
            grant_en    <= 1'b0;
            clear_en    <= 1'b0;
            clear_lines <= '0;
            issue_valid <= 1'b0;
            pending     <= '0;
            for (int f = 0; f < NUM_FUS; f++) begin
                busy_cnt[f] <= 4'd0;
            end
        end else begin
            for (int f = 0; f < NUM_FUS; f++) begin
                if (can_grant_p0 && (pick_fu_p0 == FU_W'(f))) begin
                    busy_cnt[f] <= occ_load(fu_occupancy[f*4 +: 4]);
                end else begin
                    busy_cnt[f] <= dec_sat(busy_cnt[f]);
                end
            end
            if (can_grant_p0) begin
                grant_en    <= 1'b1;
                grant_index <= pick_idx_p0;
                clear_en    <= 1'b1;
                clear_lines <= clear_next_p0;
                issue_valid <= 1'b1;
                issue_index <= pick_idx_p0;
                issue_fu    <= pick_fu_p0;
                rr_ptr      <= pick_idx_p0 + IDX_W'(1);
                pending     <= pending_next_p0;
            end else begin
                grant_en    <= 1'b0;
                clear_en    <= 1'b0;
                clear_lines <= '0;
                pending     <= '0;
                if (issue_ready && issue_valid) begin
                    issue_valid <= 1'b0;
                end
            end
        end
    end

endmodule
